vram_arbiter: RTL and testbench

Single-port work/video RAM arbiter for the SCV core. It shares one synchronous-read RAM between two requesters: the uPD7800 CPU bus, decoded by address, and the video fetch engine, which issues fixed-length burst reads. The CPU has absolute priority and deterministic read latency. Video bursts fill every RAM cycle the CPU does not use. It sits between the CPU's A/DB/RDB/WRB bus and the RAM macro.

---
 rtl/vram_arbiter_if.sv | 32 +++
 rtl/vram_arbiter.sv | 144 ++++++++++++++
 tb/tb_vram_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the RAM macro.
// The slave modport is the arbiter's view of the bundle.
interface vram_arbiter_if #(
  parameter int AW = 12
);
  logic          CPU_SEL;
  logic [AW-1:0] CPU_A;
  logic [7:0]    CPU_DI;
  logic          CPU_RDB;
  logic          CPU_WRB;
  logic [7:0]    CPU_DO;
  logic          VID_REQ;
  logic [AW-1:0] VID_A;
  logic          VID_BUSY;
  logic [7:0]    VID_D;
  logic          VID_DV;
  logic          VID_DONE;
  logic [AW-1:0] RAM_A;
  logic          RAM_WE;
  logic [7:0]    RAM_DI;
  logic [7:0]    RAM_DO;

  modport slave (
    input  CPU_SEL, CPU_A, CPU_DI, CPU_RDB, CPU_WRB, VID_REQ, VID_A, RAM_DO,
    output CPU_DO, VID_BUSY, VID_D, VID_DV, VID_DONE, RAM_A, RAM_WE, RAM_DI
  );

  modport master (
    output CPU_SEL, CPU_A, CPU_DI, CPU_RDB, CPU_WRB, VID_REQ, VID_A, RAM_DO,
    input  CPU_DO, VID_BUSY, VID_D, VID_DV, VID_DONE, RAM_A, RAM_WE, RAM_DI
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port RAM arbiter: CPU accesses take absolute priority with fixed latency,
// video burst reads fill every remaining slot and are returned in address order.
module vram_arbiter #(
  parameter int AW    = 12,
  parameter int BURST = 8
) (
  input logic           CLK,
  input logic           RES,
  vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VID} tag_t;
  typedef enum logic [1:0] {SLOT_IDLE, SLOT_CPU_WR, SLOT_CPU_RD, SLOT_VID_RD} slot_t;
  typedef enum logic {VS_IDLE, VS_RUN} vstate_t;

  localparam logic [8:0]    BURST_N    = 9'(BURST);
  localparam logic [8:0]    BURST_LAST = 9'(BURST - 1);
  localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic          act_rd, act_wr;
  logic          rd_p0, rd_p1, wr_p0, wr_p1;
  logic          rd_arm, wr_arm;
  logic          rd_start, wr_start;
  slot_t         slot;
  vstate_t       vstate, vstate_nxt;
  logic          burst_load;
  logic [AW-1:0] vaddr;
  logic [8:0]    issued, returned;
  tag_t          tag_p1, tag_p2;

  assign act_rd = bus.CPU_SEL & ~bus.CPU_RDB;
  assign act_wr = bus.CPU_SEL & ~bus.CPU_WRB;

  // Strobe history; the arm flags stay low until a strobe has been seen high,
  // so a strobe already low when reset releases cannot start an access.
  always_ff @(posedge CLK) begin
    if (RES) begin
      rd_p0  <= 1'b0;
      rd_p1  <= 1'b0;
      wr_p0  <= 1'b0;
      wr_p1  <= 1'b0;
      rd_arm <= 1'b0;
      wr_arm <= 1'b0;
    end else begin
      rd_p0 <= act_rd;
      rd_p1 <= rd_p0;
      wr_p0 <= act_wr;
      wr_p1 <= wr_p0;
      if (!act_rd) rd_arm <= 1'b1;
      if (!act_wr) wr_arm <= 1'b1;
    end
  end

  assign rd_start = rd_p0 & ~rd_p1 & rd_arm;
  assign wr_start = wr_p0 & ~wr_p1 & wr_arm;

  always_ff @(posedge CLK) begin
    if (RES) vstate <= VS_IDLE;
    else     vstate <= vstate_nxt;
  end

  always_comb begin
    vstate_nxt = vstate;
    burst_load = 1'b0;
    case (vstate)
      VS_IDLE: if (bus.VID_REQ) begin
        vstate_nxt = VS_RUN;
        burst_load = 1'b1;
      end
      VS_RUN:  if (bus.VID_DONE) vstate_nxt = VS_IDLE;
      default: vstate_nxt = VS_IDLE;
    endcase
  end

  assign bus.VID_BUSY = (vstate == VS_RUN);

  // A read strobe falling while a write strobe is still held belongs to that write.
  always_comb begin
    slot = SLOT_IDLE;
    if (wr_start)                               slot = SLOT_CPU_WR;
    else if (rd_start && !wr_p0)                slot = SLOT_CPU_RD;
    else if (vstate == VS_RUN && issued != BURST_N) slot = SLOT_VID_RD;
  end

  // Stage 0: slot issue onto the RAM port
  always_ff @(posedge CLK) begin
    if (RES) begin
      bus.RAM_A  <= '0;
      bus.RAM_WE <= 1'b0;
      bus.RAM_DI <= '0;
      tag_p1     <= TAG_NONE;
      vaddr      <= '0;
      issued     <= '0;
    end else begin
      bus.RAM_WE <= 1'b0;
      tag_p1     <= TAG_NONE;
      case (slot)
        SLOT_CPU_WR: begin
          bus.RAM_A  <= bus.CPU_A;
          bus.RAM_DI <= bus.CPU_DI;
          bus.RAM_WE <= 1'b1;
        end
        SLOT_CPU_RD: begin
          bus.RAM_A <= bus.CPU_A;
          tag_p1    <= TAG_CPU;
        end
        SLOT_VID_RD: begin
          bus.RAM_A <= vaddr;
          tag_p1    <= TAG_VID;
          vaddr     <= vaddr + ADDR_ONE;
          issued    <= issued + 9'd1;
        end
        default: ;
      endcase
      if (burst_load) begin
        vaddr  <= bus.VID_A;
        issued <= '0;
      end
    end
  end

  // Stage 1 -> 2: tag follows the RAM read latency, then the data is steered
  always_ff @(posedge CLK) begin
    if (RES) begin
      tag_p2       <= TAG_NONE;
      returned     <= '0;
      bus.CPU_DO   <= '0;
      bus.VID_D    <= '0;
      bus.VID_DV   <= 1'b0;
      bus.VID_DONE <= 1'b0;
    end else begin
      tag_p2       <= tag_p1;
      bus.VID_DV   <= 1'b0;
      bus.VID_DONE <= 1'b0;
      if (tag_p2 == TAG_CPU) bus.CPU_DO <= bus.RAM_DO;
      if (tag_p2 == TAG_VID) begin
        bus.VID_D  <= bus.RAM_DO;
        bus.VID_DV <= 1'b1;
        returned   <= returned + 9'd1;
        if (returned == BURST_LAST) bus.VID_DONE <= 1'b1;
      end
      if (burst_load) returned <= '0;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: CPU write/read, plain, wrapped and contended
// bursts, and reset in the middle of a burst, against a behavioural RAM.
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(12)) bus ();
  vram_arbiter #(.AW(12), .BURST(8)) dut (.CLK(clk), .RES(res), .bus(bus));

  logic [7:0]  mem [0:4095];
  logic        ld_we;
  logic [11:0] ld_a;
  logic [7:0]  ld_d;

  always @(posedge clk) begin
    if (ld_we)           mem[ld_a] <= ld_d;
    else if (bus.RAM_WE) mem[bus.RAM_A] <= bus.RAM_DI;
    bus.RAM_DO <= mem[bus.RAM_A];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic wr, input logic [11:0] a, input logic [7:0] d);
    bus.CPU_SEL = 1'b1;
    bus.CPU_A   = a;
    bus.CPU_DI  = d;
    if (wr) bus.CPU_WRB = 1'b0;
    else    bus.CPU_RDB = 1'b0;
  endtask

  task automatic cpu_release;
    bus.CPU_RDB = 1'b1;
    bus.CPU_WRB = 1'b1;
    bus.CPU_SEL = 1'b0;
  endtask

  // g = relative edge of a CPU read slot inside the burst (0: none).
  task automatic burst(input string tag, input logic [11:0] base, input logic [7:0] dofs,
                       input int g, input logic [11:0] ca, input logic [7:0] cexp);
    int tv[8];
    int last, jr, jd;
    logic [11:0] ea;
    for (int j = 0; j < 8; j++) tv[j] = (g > 0 && j + 1 >= g) ? j + 2 : j + 1;
    last = tv[7];
    bus.VID_REQ = 1'b1;
    bus.VID_A   = base;
    if (g == 1) cpu_drive(1'b0, ca, 8'h00);
    for (int k = 0; k <= last + 4; k++) begin
      tick;
      if (k == 0) begin
        bus.VID_REQ = 1'b0;
        check({tag, "_busy_set"}, 32'(bus.VID_BUSY), 32'd1);
      end else begin
        jr = -1;
        jd = -1;
        for (int j = 0; j < 8; j++) begin
          if (tv[j] == k)     jr = j;
          if (tv[j] + 2 == k) jd = j;
        end
        check({tag, "_ram_we"}, 32'(bus.RAM_WE), 32'd0);
        if (jr >= 0) begin
          ea = base + 12'(jr);
          check({tag, "_ram_a"}, 32'(bus.RAM_A), 32'(ea));
        end
        if (g > 0 && k == g) check({tag, "_cpu_ram_a"}, 32'(bus.RAM_A), 32'(ca));
        check({tag, "_dv"}, 32'(bus.VID_DV), 32'(jd >= 0));
        if (jd >= 0) check({tag, "_vid_d"}, 32'(bus.VID_D), 32'(dofs + 8'(jd)));
        check({tag, "_done"}, 32'(bus.VID_DONE), 32'(k == last + 2));
        check({tag, "_busy"}, 32'(bus.VID_BUSY), 32'(k <= last + 2));
        if (g > 0 && k == g + 2) begin
          check({tag, "_cpu_do"}, 32'(bus.CPU_DO), 32'(cexp));
          cpu_release;
        end
      end
      if (g > 1 && k == g - 2) cpu_drive(1'b0, ca, 8'h00);
    end
  endtask

  initial begin
    int   we_cnt;
    logic any_bad;
    res         = 1'b1;
    ld_we       = 1'b0;
    ld_a        = '0;
    ld_d        = '0;
    bus.CPU_SEL = 1'b0;
    bus.CPU_A   = '0;
    bus.CPU_DI  = '0;
    bus.CPU_RDB = 1'b1;
    bus.CPU_WRB = 1'b1;
    bus.VID_REQ = 1'b0;
    bus.VID_A   = '0;

    tick;
    tick;
    check("rst_cpu_do",   32'(bus.CPU_DO),   32'd0);
    check("rst_vid_d",    32'(bus.VID_D),    32'd0);
    check("rst_vid_dv",   32'(bus.VID_DV),   32'd0);
    check("rst_vid_done", 32'(bus.VID_DONE), 32'd0);
    check("rst_vid_busy", 32'(bus.VID_BUSY), 32'd0);
    check("rst_ram_a",    32'(bus.RAM_A),    32'd0);
    check("rst_ram_we",   32'(bus.RAM_WE),   32'd0);
    check("rst_ram_di",   32'(bus.RAM_DI),   32'd0);
    res = 1'b0;

    // Idle period doubles as the memory preload window.
    any_bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_we = 1'b1;
      if (i < 8) begin
        ld_a = 12'h100 + 12'(i);
        ld_d = 8'(i);
      end else begin
        ld_a = 12'hFFE + 12'(i - 8);
        ld_d = 8'h80 + 8'(i - 8);
      end
      tick;
      any_bad = any_bad | bus.RAM_WE;
    end
    ld_we = 1'b0;
    tick;
    check("idle_no_we", 32'(any_bad), 32'd0);

    cpu_drive(1'b1, 12'h123, 8'h5A);
    we_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (bus.RAM_WE) we_cnt++;
      if (c == 2) begin
        check("wr_ram_we", 32'(bus.RAM_WE), 32'd1);
        check("wr_ram_a",  32'(bus.RAM_A),  32'h123);
        check("wr_ram_di", 32'(bus.RAM_DI), 32'h5A);
      end
      if (c == 4) cpu_release;
    end
    check("wr_pulses", 32'(we_cnt), 32'd1);
    check("wr_mem",    32'(mem[12'h123]), 32'h5A);

    cpu_drive(1'b0, 12'h123, 8'h00);
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 2) begin
        check("rd_ram_a",  32'(bus.RAM_A),  32'h123);
        check("rd_ram_we", 32'(bus.RAM_WE), 32'd0);
      end
      if (c == 3) check("rd_not_early", 32'(bus.CPU_DO), 32'd0);
      if (c == 4) begin
        check("rd_cpu_do", 32'(bus.CPU_DO), 32'h5A);
        cpu_release;
      end
      if (c == 8) check("rd_cpu_do_hold", 32'(bus.CPU_DO), 32'h5A);
    end

    burst("unl",  12'h100, 8'h00, 0, 12'h000, 8'h00);
    burst("wrap", 12'hFFE, 8'h80, 0, 12'h000, 8'h00);
    burst("mid",  12'h100, 8'h00, 4, 12'h123, 8'h5A);
    burst("coin", 12'h100, 8'h00, 1, 12'h123, 8'h5A);

    bus.VID_REQ = 1'b1;
    bus.VID_A   = 12'h100;
    tick;
    bus.VID_REQ = 1'b0;
    for (int k = 1; k <= 5; k++) tick;
    check("mrst_third_dv", 32'(bus.VID_DV), 32'd1);
    check("mrst_third_d",  32'(bus.VID_D),  32'd2);
    res = 1'b1;
    tick;
    res = 1'b0;
    check("mrst_busy_clr", 32'(bus.VID_BUSY), 32'd0);
    any_bad = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      any_bad = any_bad | bus.VID_DV | bus.VID_DONE | bus.VID_BUSY;
    end
    check("mrst_quiet", 32'(any_bad), 32'd0);
    burst("post", 12'h100, 8'h00, 0, 12'h000, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
